// File: rtl/conv_index_gen.sv
// Index sequencer for direct-form linear convolution.
// Walks output n and tap k, presenting one (n,k) beat per accepted handshake.
module conv_index_gen #(
    parameter  int XLEN = 4,
    parameter  int HLEN = 3,
    localparam int NY   = XLEN + HLEN - 1,
    localparam int XW   = (XLEN > 1) ? $clog2(XLEN) : 1,
    localparam int HW   = (HLEN > 1) ? $clog2(HLEN) : 1,
    localparam int YW   = (NY > 1) ? $clog2(NY) : 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic          clr,
    input  logic          ready,
    output logic          beat_valid,
    output logic [YW-1:0] y_idx,
    output logic [HW-1:0] h_idx,
    output logic [XW-1:0] x_idx,
    output logic          tap_valid,
    output logic          first,
    output logic          last,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [HW-1:0] K_LAST = HW'(HLEN - 1);
    localparam logic [YW-1:0] N_LAST = YW'(NY - 1);
    localparam logic [YW:0]   X_MAX  = (YW+1)'(XLEN - 1);

    state_t        state_q, state_d;
    logic [YW-1:0] n_q, n_d;
    logic [HW-1:0] k_q, k_d;

    logic          run;
    logic [YW:0]   n_ext;
    logic [YW:0]   k_ext;
    logic [YW:0]   diff;
    logic          tv;

    // State and loop counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
        end
    end

    // Next state: clr wins, then start in IDLE, then beat acceptance
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        k_d     = k_q;
        if (clr) begin
            state_d = S_IDLE;
            n_d     = '0;
            k_d     = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_RUN;
                        n_d     = '0;
                        k_d     = '0;
                    end
                end
                S_RUN: begin
                    if (ready) begin
                        if (k_q == K_LAST) begin
                            k_d = '0;
                            if (n_q == N_LAST) begin
                                state_d = S_DONE;
                                n_d     = '0;
                            end else begin
                                n_d = n_q + YW'(1);
                            end
                        end else begin
                            k_d = k_q + HW'(1);
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    n_d     = '0;
                    k_d     = '0;
                end
            endcase
        end
    end

    // Beat outputs from registered state only; n-k evaluated one bit wider
    always_comb begin
        run   = (state_q == S_RUN);
        n_ext = (YW+1)'(n_q);
        k_ext = (YW+1)'(k_q);
        diff  = n_ext - k_ext;
        tv    = run && (n_ext >= k_ext) && (diff <= X_MAX);

        beat_valid = run;
        y_idx      = run ? n_q : '0;
        h_idx      = run ? k_q : '0;
        tap_valid  = tv;
        x_idx      = tv ? XW'(diff) : '0;
        first      = run && (k_q == '0);
        last       = run && (k_q == K_LAST);
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_conv_index_gen.sv
// Bench for conv_index_gen: three parameter sets share stimulus,
// each checked every cycle against a beat-position model.
module tb_conv_index_gen;

    logic clk = 1'b0;
    logic rstn, start, clr, ready;

    logic       bv0, tv0, f0, l0, bz0, dn0;
    logic [2:0] y0;
    logic [1:0] h0, x0;
    logic       bv1, tv1, f1, l1, bz1, dn1;
    logic [0:0] y1, h1, x1;
    logic       bv2, tv2, f2, l2, bz2, dn2;
    logic [2:0] y2, x2;
    logic [1:0] h2;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    bit clr_stats = 1'b0;

    int XL[3] = '{4, 1, 5};
    int HL[3] = '{3, 1, 4};
    int ms[3];
    int mp[3];
    int beat_cnt[3];
    int tv_cnt[3];
    int done_cyc[3];
    int done_cnt[3];

    always #5 clk = ~clk;

    conv_index_gen #(.XLEN(4), .HLEN(3)) u0 (
        .clk(clk), .rstn(rstn), .start(start), .clr(clr), .ready(ready),
        .beat_valid(bv0), .y_idx(y0), .h_idx(h0), .x_idx(x0),
        .tap_valid(tv0), .first(f0), .last(l0), .busy(bz0), .done(dn0)
    );

    conv_index_gen #(.XLEN(1), .HLEN(1)) u1 (
        .clk(clk), .rstn(rstn), .start(start), .clr(clr), .ready(ready),
        .beat_valid(bv1), .y_idx(y1), .h_idx(h1), .x_idx(x1),
        .tap_valid(tv1), .first(f1), .last(l1), .busy(bz1), .done(dn1)
    );

    conv_index_gen #(.XLEN(5), .HLEN(4)) u2 (
        .clk(clk), .rstn(rstn), .start(start), .clr(clr), .ready(ready),
        .beat_valid(bv2), .y_idx(y2), .h_idx(h2), .x_idx(x2),
        .tap_valid(tv2), .first(f2), .last(l2), .busy(bz2), .done(dn2)
    );

    function automatic int pack(bit b, bit d, bit v, bit t, bit f, bit l,
                                int y, int h, int x);
        return (int'(b) << 29) | (int'(d) << 28) | (int'(v) << 27) |
               (int'(t) << 26) | (int'(f) << 25) | (int'(l) << 24) |
               (y << 16) | (h << 8) | x;
    endfunction

    function automatic int act_pack(int i);
        case (i)
            0: return pack(bz0, dn0, bv0, tv0, f0, l0,
                           int'(y0), int'(h0), int'(x0));
            1: return pack(bz1, dn1, bv1, tv1, f1, l1,
                           int'(y1), int'(h1), int'(x1));
            default: return pack(bz2, dn2, bv2, tv2, f2, l2,
                                 int'(y2), int'(h2), int'(x2));
        endcase
    endfunction

    // Expected outputs: beat p of run is (n,k) = (p/HLEN, p%HLEN)
    function automatic int exp_pack(int i);
        int n, k, d;
        bit v, t;
        v = (ms[i] == 1);
        n = v ? mp[i] / HL[i] : 0;
        k = v ? mp[i] % HL[i] : 0;
        d = n - k;
        t = v && (d >= 0) && (d < XL[i]);
        return pack(ms[i] != 0, ms[i] == 2, v, t, v && (k == 0),
                    v && (k == HL[i] - 1), n, k, t ? d : 0);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t",
                      name, act, exp, $time);
    endtask

    // Model: 0 idle, 1 run at beat position mp, 2 done
    initial begin
        for (int i = 0; i < 3; i++) begin
            ms[i] = 0;
            mp[i] = 0;
        end
        forever begin
            @(posedge clk or negedge rstn);
            for (int i = 0; i < 3; i++) begin
                if (!rstn || clr) begin
                    ms[i] = 0;
                    mp[i] = 0;
                end else if (ms[i] == 0) begin
                    if (start) begin
                        ms[i] = 1;
                        mp[i] = 0;
                    end
                end else if (ms[i] == 1) begin
                    if (ready) begin
                        if (mp[i] == (XL[i] + HL[i] - 1) * HL[i] - 1) begin
                            ms[i] = 2;
                            mp[i] = 0;
                        end else begin
                            mp[i] = mp[i] + 1;
                        end
                    end
                end else begin
                    ms[i] = 0;
                end
            end
        end
    end

    // Per-cycle compare and run statistics
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                int a;
                a = act_pack(i);
                chk($sformatf("cycle_u%0d", i), a, exp_pack(i));
                if (clr_stats) begin
                    beat_cnt[i] = 0;
                    tv_cnt[i]   = 0;
                    done_cyc[i] = -1;
                    done_cnt[i] = 0;
                end else begin
                    if (a[27] && ready) begin
                        beat_cnt[i]++;
                        if (a[26]) tv_cnt[i]++;
                    end
                    if (a[28]) begin
                        done_cnt[i]++;
                        if (done_cyc[i] < 0) done_cyc[i] = cyc;
                    end
                end
            end
        end
    end

    task automatic reset_stats();
        clr_stats = 1'b1;
        @(negedge clk);
        #1;
        clr_stats = 1'b0;
    endtask

    task automatic begin_run();
        reset_stats();
        ready = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // mode 0: ready held 1; mode 1: ready toggles, low on odd cycles
    task automatic do_run(input int mode);
        bit all_done;
        begin_run();
        all_done = 1'b0;
        while (!all_done && cyc < 200) begin
            ready = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
            if (mode == 0) begin
                if (cyc == 1) begin
                    chk("b00", act_pack(0), pack(1, 0, 1, 1, 1, 0, 0, 0, 0));
                    chk("u1_b0", act_pack(1), pack(1, 0, 1, 1, 1, 1, 0, 0, 0));
                    chk("u2_b0", act_pack(2), pack(1, 0, 1, 1, 1, 0, 0, 0, 0));
                end
                if (cyc == 2)
                    chk("b01", act_pack(0), pack(1, 0, 1, 0, 0, 0, 0, 1, 0));
                if (cyc == 3)
                    chk("b02", act_pack(0), pack(1, 0, 1, 0, 0, 1, 0, 2, 0));
                if (cyc == 18)
                    chk("b52", act_pack(0), pack(1, 0, 1, 1, 0, 1, 5, 2, 3));
            end
            step();
            all_done = (done_cyc[0] > 0) && (done_cyc[1] > 0) &&
                       (done_cyc[2] > 0);
        end
        ready = 1'b1;
        chk("run_complete", int'(all_done), 1);
        chk("beats_u0", beat_cnt[0], 18);
        chk("beats_u1", beat_cnt[1], 1);
        chk("beats_u2", beat_cnt[2], 32);
        chk("taps_u0", tv_cnt[0], 12);
        chk("taps_u1", tv_cnt[1], 1);
        chk("taps_u2", tv_cnt[2], 20);
        chk("done_cyc_u0", done_cyc[0], (mode == 0) ? 19 : 37);
        chk("done_cyc_u1", done_cyc[1], (mode == 0) ? 2 : 3);
        chk("done_cyc_u2", done_cyc[2], (mode == 0) ? 33 : 65);
        chk("done_once_u0", done_cnt[0], 1);
    endtask

    initial begin
        rstn  = 1'b0;
        start = 1'b0;
        clr   = 1'b0;
        ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_u0", act_pack(0), 0);
        chk("reset_u1", act_pack(1), 0);
        chk("reset_u2", act_pack(2), 0);
        rstn = 1'b1;
        step();

        do_run(0);
        do_run(1);

        begin_run();
        while (cyc < 8) step();
        chk("pre_rst_b7", act_pack(0), pack(1, 0, 1, 1, 0, 0, 2, 1, 1));
        #2;
        rstn = 1'b0;
        #1;
        chk("async_rst_u0", act_pack(0), 0);
        chk("async_rst_u2", act_pack(2), 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        do_run(0);

        begin_run();
        while (cyc < 8) begin
            start = (cyc == 3);
            step();
        end
        start = 1'b0;
        chk("pre_clr_b21", act_pack(0), pack(1, 0, 1, 1, 0, 0, 2, 1, 1));
        clr   = 1'b1;
        start = 1'b1;
        step();
        clr   = 1'b0;
        start = 1'b0;
        chk("after_clr_u0", act_pack(0), 0);
        repeat (25) step();
        chk("no_done_u0", done_cnt[0], 0);
        chk("no_done_u2", done_cnt[2], 0);
        clr   = 1'b1;
        start = 1'b1;
        step();
        clr   = 1'b0;
        start = 1'b0;
        chk("start_clr_idle", act_pack(0), 0);
        do_run(0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
